// File: rtl/instr_fetch_queue.sv
// Fetch stage: one outstanding I-cache request, small PC/word FIFO toward the decoder.
// Optional PREDECODE_JAL_EN redirects fetch to the target of a fetched JAL.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_data,
  input  logic        dec_ready,
  output logic        to_dec,
  output logic [31:0] to_dec_pc,
  output logic [31:0] to_dec_inst
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  localparam logic [QUEUE_WIDTH:0] DEPTH_C = (QUEUE_WIDTH + 1)'(QUEUE_DEPTH);

  state_t                 state, state_nxt;
  logic [31:0]            fetch_pc, fetch_pc_nxt;
  logic [QUEUE_WIDTH-1:0] head, tail;
  logic [QUEUE_WIDTH:0]   count;
  logic [31:0]            pc_q   [QUEUE_DEPTH];
  logic [31:0]            inst_q [QUEUE_DEPTH];
  logic                   issue, push, pop;

`ifdef PREDECODE_JAL_EN
  // J-type immediate, bits [31:12] of the instruction word.
  function automatic logic signed [31:0] jal_offset(input logic [31:12] hi);
    logic signed [31:0] off;
    off = {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
    return off;
  endfunction
`endif

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    issue        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    if (rdy_in) begin
      if (clear) begin
        fetch_pc_nxt = clear_pc;
        // A response still owed by the cache must be swallowed in DROP.
        if (state == IDLE) state_nxt = IDLE;
        else               state_nxt = icache_valid ? IDLE : DROP;
      end else begin
        pop = (count != '0) && dec_ready;
        case (state)
          IDLE: if (count < DEPTH_C) begin
            issue     = 1'b1;
            state_nxt = WAIT;
          end
          WAIT: if (icache_valid) begin
            push      = 1'b1;
            state_nxt = IDLE;
`ifdef PREDECODE_JAL_EN
            if (icache_data[6:0] == 7'b1101111)
              fetch_pc_nxt = fetch_pc + 32'(jal_offset(icache_data[31:12]));
            else
              fetch_pc_nxt = fetch_pc + 32'd4;
`else
            fetch_pc_nxt = fetch_pc + 32'd4;
`endif
          end
          DROP: if (icache_valid) state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  assign icache_req  = rst_in && issue;
  assign icache_addr = icache_req ? fetch_pc : 32'h0;
  assign to_dec      = (count != '0);
  assign to_dec_pc   = pc_q[head];
  assign to_dec_inst = inst_q[head];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]   <= 32'h0;
        inst_q[i] <= 32'h0;
      end
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (rdy_in && clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          pc_q[tail]   <= fetch_pc;
          inst_q[tail] <= icache_data;
          tail         <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboarded bench for instr_fetch_queue with a behavioural I-cache responder.
module tb_instr_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, dec_ready, icache_valid;
  logic [31:0] clear_pc, icache_data;
  logic        icache_req, to_dec;
  logic [31:0] icache_addr, to_dec_pc, to_dec_inst;

  instr_fetch_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .clear_pc(clear_pc),
    .icache_req(icache_req), .icache_addr(icache_addr), .icache_valid(icache_valid),
    .icache_data(icache_data), .dec_ready(dec_ready), .to_dec(to_dec),
    .to_dec_pc(to_dec_pc), .to_dec_inst(to_dec_inst)
  );

  always #5 clk_in = ~clk_in;

  int          errors = 0, checks = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_addr, pend_addr, last_req_addr, last_pop_pc;
  int          req_count, pop_count, lat_cnt, lat;
  bit          live, jal_mode, rand_lat;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (jal_mode && a == 32'h20) return 32'h0100_006F;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a, input logic [31:0] w);
`ifdef PREDECODE_JAL_EN
    if (w[6:0] == 7'h6F)
      return a + {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
`endif
    return a + 32'd4 + (32'(w) & 32'h0);
  endfunction

  // One clock: at the falling edge run the cache responder and scoreboard,
  // then return just after the rising edge so the caller can drive inputs.
  task automatic step();
    logic [63:0] e;
    @(negedge clk_in);
    if (!rst_in) begin
      icache_valid = 1'b0;
      lat_cnt      = 0;
    end else begin
      if (icache_valid && live) icache_valid = 1'b0;
      if (rdy_in) begin
        if (clear) begin
          sb.delete();
          exp_addr = clear_pc;
        end else begin
          if (icache_req) begin
            checks++;
            if (icache_addr !== exp_addr) begin
              errors++;
              $display("FAIL req_addr: got %h expected %h", icache_addr, exp_addr);
            end
            last_req_addr = icache_addr;
            req_count++;
            sb.push_back({icache_addr, word_of(icache_addr)});
            exp_addr = next_pc(icache_addr, word_of(icache_addr));
          end
          if (to_dec && dec_ready) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL pop_empty: got pc %h expected no entry", to_dec_pc);
            end else begin
              e = sb.pop_front();
              if ({to_dec_pc, to_dec_inst} !== e) begin
                errors++;
                $display("FAIL pop_entry: got %h/%h expected %h/%h",
                         to_dec_pc, to_dec_inst, e[63:32], e[31:0]);
              end
            end
            last_pop_pc = to_dec_pc;
            pop_count++;
          end
        end
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            icache_valid = 1'b1;
            icache_data  = word_of(pend_addr);
          end
        end
        if (icache_req) begin
          pend_addr = icache_addr;
          lat_cnt   = rand_lat ? $urandom_range(1, 3) : lat;
        end
      end
    end
    live = rst_in && rdy_in;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset(input int l, input bit dr);
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; clear_pc = 32'h0; dec_ready = dr;
    lat = l; rand_lat = 1'b0;
    sb.delete(); exp_addr = 32'h0; req_count = 0; pop_count = 0;
    last_req_addr = 32'hFFFF_FFFF; last_pop_pc = 32'hFFFF_FFFF;
    step(); step();
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; clear_pc = 32'h0; dec_ready = 1'b1;
    icache_valid = 1'b0; icache_data = 32'h0; live = 1'b0; jal_mode = 1'b0;
    step();
    checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", icache_req); end
    checks++; if (icache_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", icache_addr); end
    checks++; if (to_dec !== 1'b0) begin errors++; $display("FAIL rst_to_dec: got %b expected 0", to_dec); end
    checks++; if ({to_dec_pc, to_dec_inst} !== 64'h0) begin
      errors++; $display("FAIL rst_head: got %h/%h expected 0/0", to_dec_pc, to_dec_inst);
    end
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1);
    for (int i = 0; i < 60 && pop_count < 3; i++) step();
    checks++;
    if (pop_count < 3 || last_pop_pc !== 32'h8) begin
      errors++; $display("FAIL stream: got %0d pops last pc %h expected 3 pops last pc 00000008", pop_count, last_pop_pc);
    end
  endtask

  task automatic test_full();
    do_reset(1, 1'b0);
    for (int i = 0; i < 20; i++) step();
    checks++; if (req_count != 4) begin errors++; $display("FAIL full_reqs: got %0d expected 4", req_count); end
    checks++; if (to_dec !== 1'b1 || to_dec_pc !== 32'h0 || to_dec_inst !== word_of(32'h0)) begin
      errors++; $display("FAIL full_head: got %b %h %h expected 1 00000000 %h", to_dec, to_dec_pc, to_dec_inst, word_of(32'h0));
    end
    checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL full_noreq: got %b expected 0", icache_req); end
    dec_ready = 1'b1;
    for (int i = 0; i < 40 && req_count < 5; i++) step();
    checks++; if (req_count < 5 || last_req_addr !== 32'h10) begin
      errors++; $display("FAIL full_resume: got %0d reqs addr %h expected 5 reqs addr 00000010", req_count, last_req_addr);
    end
    for (int i = 0; i < 40 && pop_count < 5; i++) step();
    checks++; if (pop_count < 5) begin errors++; $display("FAIL full_drain: got %0d pops expected 5", pop_count); end
  endtask

  task automatic test_clear();
    do_reset(3, 1'b0);
    for (int i = 0; i < 60 && req_count < 3; i++) step();
    checks++; if (last_req_addr !== 32'h8) begin errors++; $display("FAIL clr_setup: got %h expected 00000008", last_req_addr); end
    clear = 1'b1; clear_pc = 32'h100;
    step();
    clear = 1'b0;
    checks++; if (to_dec !== 1'b0) begin errors++; $display("FAIL clr_flush: got %b expected 0", to_dec); end
    dec_ready = 1'b1;
    for (int i = 0; i < 60 && req_count < 4; i++) step();
    checks++; if (req_count < 4 || last_req_addr !== 32'h100) begin
      errors++; $display("FAIL clr_redirect: got %0d reqs addr %h expected addr 00000100", req_count, last_req_addr);
    end
    for (int i = 0; i < 60 && pop_count < 1; i++) step();
    checks++; if (pop_count < 1 || last_pop_pc !== 32'h100) begin
      errors++; $display("FAIL clr_first_pop: got %h expected 00000100", last_pop_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1, 1'b0);
    rand_lat = 1'b1;
    for (int i = 0; i < 400 && pop_count < 14; i++) begin
      dec_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    checks++; if (pop_count < 14) begin errors++; $display("FAIL wrap: got %0d pops expected 14", pop_count); end
  endtask

  task automatic test_stall();
    logic        c_vld;
    logic [31:0] c_pc, c_inst;
    int          p0;
    do_reset(2, 1'b1);
    for (int i = 0; i < 60 && pop_count < 2; i++) step();
    c_vld = to_dec; c_pc = to_dec_pc; c_inst = to_dec_inst;
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (icache_req !== 1'b0 || to_dec !== c_vld || to_dec_pc !== c_pc || to_dec_inst !== c_inst) begin
        errors++; $display("FAIL stall_hold: got %b %b %h %h expected 0 %b %h %h",
                           icache_req, to_dec, to_dec_pc, to_dec_inst, c_vld, c_pc, c_inst);
      end
    end
    rdy_in = 1'b1;
    p0 = pop_count;
    for (int i = 0; i < 60 && pop_count < p0 + 4; i++) step();
    checks++; if (pop_count < p0 + 4) begin errors++; $display("FAIL stall_resume: got %0d pops expected %0d", pop_count, p0 + 4); end
  endtask

  task automatic test_jal();
    logic [31:0] tgt;
`ifdef PREDECODE_JAL_EN
    tgt = 32'h30;
`else
    tgt = 32'h24;
`endif
    jal_mode = 1'b1;
    do_reset(1, 1'b1);
    for (int i = 0; i < 100 && req_count < 10; i++) step();
    checks++; if (req_count < 10 || last_req_addr !== tgt) begin
      errors++; $display("FAIL jal_target: got %h expected %h", last_req_addr, tgt);
    end
    for (int i = 0; i < 40 && pop_count < 10; i++) step();
    checks++; if (pop_count < 10 || last_pop_pc !== tgt) begin
      errors++; $display("FAIL jal_pop: got %h expected %h", last_pop_pc, tgt);
    end
    jal_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_clear();
    test_back_to_back();
    test_stall();
    test_jal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
